// File: rtl/ycr_wbd_sram_resp_if.sv
// Purpose: burst-extended Wishbone data-bus bundle between the dmem initiator and the SRAM responder.
// Latency: n/a (wires only).
// Backpressure: wbs_bry_i from the initiator gates every beat; ack/lack/err flow back to it.
//
// Signals
//   wbs_stb_i  request valid, held with adr/we/sel/bl stable for the whole burst
//   wbs_adr_i  byte address of beat 0
//   wbs_we_i   1 = write burst
//   wbs_dat_i  write data of the current beat
//   wbs_sel_i  byte enables (writes only)
//   wbs_bl_i   beat count, 0 is treated as 1
//   wbs_bry_i  initiator ready: write data valid / read sink has room
//   wbs_dat_o  read data, non-zero only with a read ack
//   wbs_ack_o  per-beat acknowledge
//   wbs_lack_o last-beat acknowledge
//   wbs_err_o  error response, always together with ack and lack
interface ycr_wbd_sram_resp_if #(
    parameter int BL_W = 10
);
    logic            wbs_stb_i;
    logic [31:0]     wbs_adr_i;
    logic            wbs_we_i;
    logic [31:0]     wbs_dat_i;
    logic [3:0]      wbs_sel_i;
    logic [BL_W-1:0] wbs_bl_i;
    logic            wbs_bry_i;
    logic [31:0]     wbs_dat_o;
    logic            wbs_ack_o;
    logic            wbs_lack_o;
    logic            wbs_err_o;

    modport master (
        output wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
        input  wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
    );

    modport slave (
        input  wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
        output wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
    );
endinterface

// File: rtl/ycr_wbd_sram_resp.sv
// Purpose: Wishbone burst responder fronting a 1-cycle-latency single-port SRAM as a data scratchpad.
// Latency: read ack 3 cycles after stb (IDLE, issue, ack); write ack 2 cycles after stb (IDLE, write+ack).
// Backpressure: wbs_bry_i low stalls beat issue; a read already issued to the SRAM is still acked next cycle.
//
// Ports
//   core_clk, core_rst_n  clock and asynchronous active-low reset
//   wbs                   burst Wishbone slave side (see ycr_wbd_sram_resp_if)
//   mem_csb_o/web_o       SRAM chip select / write enable, both active-low
//   mem_wmask_o           SRAM byte write mask
//   mem_addr_o            SRAM word address
//   mem_din_o/dout_i      SRAM write data / read data (read data valid the cycle after issue)
module ycr_wbd_sram_resp #(
    parameter int          MEM_AW    = 9,
    parameter int          BL_W      = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0C00_0000
) (
    input  logic              core_clk,
    input  logic              core_rst_n,
    ycr_wbd_sram_resp_if.slave wbs,
    output logic              mem_csb_o,
    output logic              mem_web_o,
    output logic [3:0]        mem_wmask_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [BL_W-1:0] BL_ZERO = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic [MEM_AW-1:0] base_q,    base_d;     // word address of beat 0
    logic [BL_W-1:0]   bl_q,      bl_d;       // total beats in this burst (>= 1)
    logic [BL_W-1:0]   idx_q,     idx_d;      // beats issued to the SRAM so far
    logic              rd_vld_q,  rd_vld_d;   // SRAM read data returns this cycle
    logic              rd_last_q, rd_last_d;  // ...and it belongs to the final beat

    // Output drivers
    logic [31:0] dat_o;
    logic        ack_o;
    logic        lack_o;
    logic        err_o;

    // Helpers
    logic [MEM_AW-1:0] beat_addr;
    logic              last_beat;
    logic              in_range;
    logic              more_to_issue;

    // Byte-offset bits carry no information for a word-wide memory.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

    // The word offset is truncated to MEM_AW bits so a burst running past
    // the top word wraps back to word 0 instead of leaving the macro.
    assign beat_addr     = base_q + MEM_AW'(idx_q);
    assign last_beat     = (idx_q == (bl_q - BL_ONE));
    assign more_to_issue = (idx_q != bl_q);
    assign in_range      = (wbs.wbs_adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        bl_d      = bl_q;
        idx_d     = idx_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;

        mem_csb_o   = 1'b1;
        mem_web_o   = 1'b1;
        mem_wmask_o = 4'h0;
        mem_addr_o  = '0;
        mem_din_o   = 32'h0;

        ack_o  = 1'b0;
        lack_o = 1'b0;
        err_o  = 1'b0;
        dat_o  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                // Capture only; the SRAM is not touched until the next cycle.
                if (wbs.wbs_stb_i) begin
                    base_d = wbs.wbs_adr_i[MEM_AW+1:2];
                    bl_d   = (wbs.wbs_bl_i == BL_ZERO) ? BL_ONE : wbs.wbs_bl_i;
                    idx_d  = BL_ZERO;
                    if (!in_range) begin
                        state_d = ST_ERR;
                    end else if (wbs.wbs_we_i) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                // Issue side: one read per cycle while the initiator can sink it.
                if (wbs.wbs_bry_i && more_to_issue) begin
                    mem_csb_o  = 1'b0;
                    mem_addr_o = beat_addr;
                    idx_d      = idx_q + BL_ONE;
                    rd_vld_d   = 1'b1;
                    rd_last_d  = last_beat;
                end
                // Return side: independent of bry so an issued beat is never dropped.
                if (rd_vld_q) begin
                    ack_o = 1'b1;
                    dat_o = mem_dout_i;
                    if (rd_last_q) begin
                        lack_o  = 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_WR: begin
                // Write and ack in the same cycle; sel=0 is a harmless masked write.
                if (wbs.wbs_bry_i) begin
                    mem_csb_o   = 1'b0;
                    mem_web_o   = 1'b0;
                    mem_wmask_o = wbs.wbs_sel_i;
                    mem_din_o   = wbs.wbs_dat_i;
                    mem_addr_o  = beat_addr;
                    ack_o       = 1'b1;
                    idx_d       = idx_q + BL_ONE;
                    if (last_beat) begin
                        lack_o  = 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_ERR: begin
                ack_o   = 1'b1;
                lack_o  = 1'b1;
                err_o   = 1'b1;
                state_d = ST_GAP;
            end

            ST_GAP: begin
                // The initiator pops its request on lack; a stb still visible
                // here is stale, so it is deliberately ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            bl_q      <= '0;
            idx_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            bl_q      <= bl_d;
            idx_q     <= idx_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign wbs.wbs_dat_o  = dat_o;
    assign wbs.wbs_ack_o  = ack_o;
    assign wbs.wbs_lack_o = lack_o;
    assign wbs.wbs_err_o  = err_o;

endmodule

// File: tb/tb_ycr_wbd_sram_resp.sv
`timescale 1ns/1ps
module tb_ycr_wbd_sram_resp;

    localparam int          MEM_AW = 9;
    localparam int          BL_W   = 10;
    localparam logic [31:0] BASE   = 32'h0C00_0000;
    localparam int          NVEC   = 20;

    logic core_clk   = 1'b0;
    logic core_rst_n = 1'b0;
    always #5 core_clk = ~core_clk;

    ycr_wbd_sram_resp_if #(.BL_W(BL_W)) wbs();

    logic              mem_csb;
    logic              mem_web;
    logic [3:0]        mem_wmask;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    ycr_wbd_sram_resp #(
        .MEM_AW   (MEM_AW),
        .BL_W     (BL_W),
        .BASE_ADDR(BASE)
    ) dut (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .wbs        (wbs),
        .mem_csb_o  (mem_csb),
        .mem_web_o  (mem_web),
        .mem_wmask_o(mem_wmask),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_dout_i (mem_dout)
    );

    // SRAM model: 1-cycle read latency, byte-masked writes, preloaded on the first edge.
    logic [31:0] sram [0:(1<<MEM_AW)-1];
    logic        pre_done = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h1000_0000;
            1:       return 32'h1000_0001;
            2:       return 32'h1122_3344;
            3:       return 32'h1000_0003;
            16:      return 32'hDEAD_BEEF;
            default: return 32'h5A00_0000 | i;
        endcase
    endfunction

    always @(posedge core_clk) begin
        if (!pre_done) begin
            for (int i = 0; i < (1<<MEM_AW); i++) sram[i] <= init_word(i);
            pre_done <= 1'b1;
        end else if (!mem_csb) begin
            if (!mem_web) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= sram[mem_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_ctrl(input logic ack, input logic lack, input logic err,
                                              input logic csb, input logic web, input logic [3:0] wm,
                                              input logic [MEM_AW-1:0] a);
        return {14'b0, ack, lack, err, csb, web, wm, a};
    endfunction

    function automatic logic [31:0] dut_ctrl();
        return pack_ctrl(wbs.wbs_ack_o, wbs.wbs_lack_o, wbs.wbs_err_o, mem_csb, mem_web, mem_wmask, mem_addr);
    endfunction

    typedef struct {
        logic              stb;
        logic [31:0]       adr;
        logic              we;
        logic [31:0]       dat;
        logic [3:0]        sel;
        logic [BL_W-1:0]   bl;
        logic              bry;
        logic              e_ack;
        logic              e_lack;
        logic              e_err;
        logic              e_csb;
        logic              e_web;
        logic [3:0]        e_wmask;
        logic [MEM_AW-1:0] e_addr;
        logic [31:0]       e_din;
        logic [31:0]       e_dato;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic drive(input logic stb, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [BL_W-1:0] bl, input logic bry);
        wbs.wbs_stb_i = stb;
        wbs.wbs_adr_i = adr;
        wbs.wbs_we_i  = we;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        wbs.wbs_bl_i  = bl;
        wbs.wbs_bry_i = bry;
    endtask

    task automatic next_cycle();
        @(posedge core_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd_exp [4];
        logic [31:0] wr_dat [3];
        logic [MEM_AW-1:0] wr_adr [3];
        int  k;
        int  low_acks;
        int  ack_cyc;
        logic done;

        //              stb adr            we dat           sel      bl bry  ack lack err csb web wmask    addr     din           dat_o
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, BASE+32'h40,   1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, BASE+32'h40,   1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,4'h0,    9'h010, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, BASE+32'h40,   1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, BASE+32'h8,    1'b1, 32'h00AB0000, 4'b0100, 1, 1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, BASE+32'h8,    1'b1, 32'h00AB0000, 4'b0100, 1, 1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,4'b0100, 9'h002, 32'h00AB0000, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 32'h2000_0000, 1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 32'h2000_0000, 1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, BASE+32'h40,   1'b0, 32'h0,        4'hF,    1, 1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[12] = '{1'b1, BASE+32'h8,    1'b0, 32'h0,        4'hF,    0, 1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[13] = '{1'b1, BASE+32'h8,    1'b0, 32'h0,        4'hF,    0, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,4'h0,    9'h002, 32'h0,        32'h0};
        tbl[14] = '{1'b1, BASE+32'h8,    1'b0, 32'h0,        4'hF,    0, 1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h11AB3344};
        tbl[15] = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[16] = '{1'b1, BASE+32'hC,    1'b1, 32'hCAFEF00D, 4'hF,    1, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[17] = '{1'b1, BASE+32'hC,    1'b1, 32'hCAFEF00D, 4'hF,    1, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};
        tbl[18] = '{1'b1, BASE+32'hC,    1'b1, 32'hCAFEF00D, 4'hF,    1, 1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,4'hF,    9'h003, 32'hCAFEF00D, 32'h0};
        tbl[19] = '{1'b0, 32'h0,         1'b0, 32'h0,        4'h0,    0, 1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,    9'h000, 32'h0,        32'h0};

        // ---------------- reset ----------------
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, '0, 1'b0);
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        check32("reset_ctrl", dut_ctrl(), pack_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, '0));
        check32("reset_dat_o", wbs.wbs_dat_o, 32'h0);
        next_cycle();
        core_rst_n = 1'b1;

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].stb, tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel, tbl[i].bl, tbl[i].bry);
            @(negedge core_clk);
            check32($sformatf("vec%0d_ctrl", i), dut_ctrl(),
                    pack_ctrl(tbl[i].e_ack, tbl[i].e_lack, tbl[i].e_err, tbl[i].e_csb, tbl[i].e_web,
                              tbl[i].e_wmask, tbl[i].e_addr));
            check32($sformatf("vec%0d_din", i), mem_din, tbl[i].e_din);
            check32($sformatf("vec%0d_dat_o", i), wbs.wbs_dat_o, tbl[i].e_dato);
            next_cycle();
        end
        check32("sram_word2_merged", sram[2], 32'h11AB3344);

        // ---------------- burst read bl=4 with a 2-cycle bry gap ----------------
        rd_exp[0] = 32'h1000_0000;
        rd_exp[1] = 32'h1000_0001;
        rd_exp[2] = 32'h11AB_3344;
        rd_exp[3] = 32'hCAFE_F00D;
        drive(1'b1, BASE, 1'b0, 32'h0, 4'hF, 10'd4, 1'b1);
        k = 0; low_acks = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            wbs.wbs_bry_i = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            @(negedge core_clk);
            if (!wbs.wbs_bry_i) check32("burst_rd_no_issue_bry_low", {31'b0, mem_csb}, 32'd1);
            if (wbs.wbs_ack_o) begin
                if (k < 4) check32($sformatf("burst_rd_dat%0d", k), wbs.wbs_dat_o, rd_exp[k]);
                check32($sformatf("burst_rd_lack%0d", k), {31'b0, wbs.wbs_lack_o}, (k == 3) ? 32'd1 : 32'd0);
                if (!wbs.wbs_bry_i) low_acks++;
                k++;
                if (wbs.wbs_lack_o) done = 1'b1;
            end
            next_cycle();
        end
        wbs.wbs_stb_i = 1'b0;
        check32("burst_rd_beats", k, 32'd4);
        check32("burst_rd_acks_while_bry_low", low_acks, 32'd1);
        next_cycle();

        // ---------------- burst write bl=3 wrapping past word 511 ----------------
        wr_dat[0] = 32'hA1A1_0001; wr_dat[1] = 32'hA2A2_0002; wr_dat[2] = 32'hA3A3_0003;
        wr_adr[0] = 9'd511;        wr_adr[1] = 9'd0;          wr_adr[2] = 9'd1;
        drive(1'b1, BASE + 32'h7FC, 1'b1, wr_dat[0], 4'hF, 10'd3, 1'b1);
        k = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (k < 3) wbs.wbs_dat_i = wr_dat[k];
            @(negedge core_clk);
            if (wbs.wbs_ack_o) begin
                if (k < 3) check32($sformatf("burst_wr_addr%0d", k), {23'b0, mem_addr}, {23'b0, wr_adr[k]});
                check32($sformatf("burst_wr_strobe%0d", k), {30'b0, mem_csb, mem_web}, 32'd0);
                check32($sformatf("burst_wr_lack%0d", k), {31'b0, wbs.wbs_lack_o}, (k == 2) ? 32'd1 : 32'd0);
                k++;
                if (wbs.wbs_lack_o) done = 1'b1;
            end
            next_cycle();
        end
        wbs.wbs_stb_i = 1'b0;
        check32("burst_wr_beats", k, 32'd3);
        check32("burst_wr_word511", sram[511], wr_dat[0]);
        check32("burst_wr_word0", sram[0], wr_dat[1]);
        check32("burst_wr_word1", sram[1], wr_dat[2]);
        check32("burst_wr_word2_untouched", sram[2], 32'h11AB3344);
        next_cycle();

        // ---------------- reset in the middle of a bl=8 read ----------------
        drive(1'b1, BASE + 32'h40, 1'b0, 32'h0, 4'hF, 10'd8, 1'b1);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge core_clk);
            if (wbs.wbs_ack_o) k++;
            if (k == 2) break;
            next_cycle();
        end
        check32("rst_mid_acks_before", k, 32'd2);
        #1;
        core_rst_n    = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        #1;
        check32("rst_mid_ctrl", dut_ctrl(), pack_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, '0));
        check32("rst_mid_din", mem_din, 32'h0);
        check32("rst_mid_dat_o", wbs.wbs_dat_o, 32'h0);
        k = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge core_clk);
            if (wbs.wbs_ack_o || !mem_csb) k++;
        end
        check32("rst_hold_quiet", k, 32'd0);
        next_cycle();
        core_rst_n = 1'b1;
        next_cycle();

        drive(1'b1, BASE + 32'h40, 1'b0, 32'h0, 4'hF, 10'd1, 1'b1);
        ack_cyc = -1;
        for (int c = 0; c < 10 && ack_cyc < 0; c++) begin
            @(negedge core_clk);
            if (wbs.wbs_ack_o) begin
                ack_cyc = c;
                check32("post_rst_rd_dat", wbs.wbs_dat_o, 32'hDEADBEEF);
                check32("post_rst_rd_lack_err", {30'b0, wbs.wbs_lack_o, wbs.wbs_err_o}, 32'd2);
            end
            next_cycle();
        end
        wbs.wbs_stb_i = 1'b0;
        check32("post_rst_rd_ack_cycle", ack_cyc, 32'd2);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
